// File: rtl/fetch_pkg.sv
// Shared fetch-stage types: FSM state encoding and the default datapath width.
package fetch_pkg;

   localparam int unsigned FETCH_L = 16;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_HALT = 2'd2
   } fetch_state_e;

endpackage : fetch_pkg

// File: rtl/fetch_controller.sv
// Fetch controller: owns the PC, addresses the combinational instruction
// memory and registers each returned word into a one-entry slot for decode.
//
// Handshake: InstrValid/InstrOut/InstrPc form a valid/ready source. A word
// transfers on a rising edge where InstrValid=1 and InstrReady=1. While
// InstrValid=1 and InstrReady=0 the slot contents are frozen. InstrValid never
// depends combinationally on InstrReady. Redirect flushes the slot regardless
// of InstrReady.
module fetch_controller
   import fetch_pkg::*;
#(
   parameter int unsigned    L            = FETCH_L,
   parameter logic [L-1:0]   RESET_PC     = '0,
   parameter bit             HALT_ON_ZERO = 1'b0
) (
   input  logic         Clk,
   input  logic         Rst_n,
   input  logic         Start,
   output logic [L-1:0] Address,
   input  logic [L-1:0] MemInstruction,
   output logic [L-1:0] InstrOut,
   output logic [L-1:0] InstrPc,
   output logic         InstrValid,
   input  logic         InstrReady,
   input  logic         Redirect,
   input  logic [L-1:0] RedirectPc,
   output logic         Halted,
   output fetch_state_e DbgState
);

   fetch_state_e state_q, state_d;
   logic [L-1:0] pc_q, pc_d;
   logic [L-1:0] instr_q, instr_d;
   logic [L-1:0] ipc_q, ipc_d;
   logic         valid_q, valid_d;
   logic         slot_free;
   logic         zero_word;

   assign slot_free = !valid_q || InstrReady;
   assign zero_word = HALT_ON_ZERO && (MemInstruction == '0);

   // Next-state logic: Redirect overrides everything, then per-state capture/halt.
   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      instr_d = instr_q;
      ipc_d   = ipc_q;
      valid_d = valid_q;

      if (Redirect) begin
         // The held word counts as consumed; the target is captured next edge.
         pc_d    = RedirectPc;
         valid_d = 1'b0;
         state_d = ST_RUN;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (Start) state_d = ST_RUN;
            end
            ST_RUN: begin
               if (slot_free) begin
                  if (zero_word) begin
                     // Do not issue the zero word; PC stays on it.
                     state_d = ST_HALT;
                     valid_d = 1'b0;
                  end else begin
                     instr_d = MemInstruction;
                     ipc_d   = pc_q;
                     valid_d = 1'b1;
                     pc_d    = pc_q + L'(1);
                  end
               end
            end
            ST_HALT: begin
               // A word captured before halting still drains to decode.
               if (valid_q && InstrReady) valid_d = 1'b0;
            end
            default: state_d = ST_IDLE;
         endcase
      end
   end

   // State, PC and output slot registers.
   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         state_q <= ST_IDLE;
         pc_q    <= RESET_PC;
         instr_q <= '0;
         ipc_q   <= '0;
         valid_q <= 1'b0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         instr_q <= instr_d;
         ipc_q   <= ipc_d;
         valid_q <= valid_d;
      end
   end

   assign Address    = pc_q;
   assign InstrOut   = instr_q;
   assign InstrPc    = ipc_q;
   assign InstrValid = valid_q;
   assign Halted     = (state_q == ST_HALT);
   assign DbgState   = state_q;

endmodule : fetch_controller

// File: tb/tb_fetch_controller.sv
// Bench for fetch_controller: two instances (no-halt with RESET_PC=1, and
// halt-on-zero with RESET_PC=25) sharing clock and reset. Memory holds n at
// address n for n=1..30 and 0 elsewhere.
module tb_fetch_controller;
   import fetch_pkg::*;

   logic clk;
   logic rst_n;

   // Instance 0 signals
   logic         start0, ready0, redirect0, halted0, valid0;
   logic [15:0]  rpc0, addr0, mem0, out0, ipc0;
   fetch_state_e st0;

   // Instance 1 signals
   logic         start1, ready1, redirect1, halted1, valid1;
   logic [15:0]  rpc1, addr1, mem1, out1, ipc1;
   fetch_state_e st1;

   logic [31:0] exp_q[$];
   logic [31:0] exp_w;
   int          errors;
   int          checks;

   function automatic logic [15:0] mem_word(input logic [15:0] a);
      return (a >= 16'd1 && a <= 16'd30) ? a : 16'h0000;
   endfunction

   assign mem0 = mem_word(addr0);
   assign mem1 = mem_word(addr1);

   fetch_controller #(.L(16), .RESET_PC(16'd1), .HALT_ON_ZERO(1'b0)) dut0 (
      .Clk(clk), .Rst_n(rst_n), .Start(start0), .Address(addr0),
      .MemInstruction(mem0), .InstrOut(out0), .InstrPc(ipc0),
      .InstrValid(valid0), .InstrReady(ready0), .Redirect(redirect0),
      .RedirectPc(rpc0), .Halted(halted0), .DbgState(st0)
   );

   fetch_controller #(.L(16), .RESET_PC(16'd25), .HALT_ON_ZERO(1'b1)) dut1 (
      .Clk(clk), .Rst_n(rst_n), .Start(start1), .Address(addr1),
      .MemInstruction(mem1), .InstrOut(out1), .InstrPc(ipc1),
      .InstrValid(valid1), .InstrReady(ready1), .Redirect(redirect1),
      .RedirectPc(rpc1), .Halted(halted1), .DbgState(st1)
   );

   // Clock
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic test_reset();
      rst_n = 1'b0;
      start0 = 0; ready0 = 0; redirect0 = 0; rpc0 = '0;
      start1 = 0; ready1 = 0; redirect1 = 0; rpc1 = '0;
      #12;
      checks++;
      if ({valid0, halted0, out0, ipc0, addr0} !== {1'b0, 1'b0, 16'h0, 16'h0, 16'h1} || st0 !== ST_IDLE) begin
         errors++;
         $display("FAIL reset0: v=%0b h=%0b out=%h pc=%h addr=%h st=%0d, want 0 0 0000 0000 0001 IDLE",
                  valid0, halted0, out0, ipc0, addr0, st0);
      end
      checks++;
      if ({valid1, halted1, out1, ipc1, addr1} !== {1'b0, 1'b0, 16'h0, 16'h0, 16'd25} || st1 !== ST_IDLE) begin
         errors++;
         $display("FAIL reset1: v=%0b h=%0b out=%h pc=%h addr=%h, want 0 0 0000 0000 0019",
                  valid1, halted1, out1, ipc1, addr1);
      end
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_start();
      @(negedge clk);
      start0 = 1; ready0 = 1;
      @(negedge clk);
      start0 = 0;
      checks++;
      if (valid0 !== 1'b0 || st0 !== ST_RUN || addr0 !== 16'd1) begin
         errors++;
         $display("FAIL start_edge1: v=%0b st=%0d addr=%h, want 0 RUN 0001", valid0, st0, addr0);
      end
      for (int i = 1; i <= 4; i++) exp_q.push_back({16'(i), 16'(i)});
      @(negedge clk);
      checks++;
      if (valid0 !== 1'b1) begin
         errors++;
         $display("FAIL start_edge2: valid=%0b, want 1", valid0);
      end
      for (int cyc = 0; cyc < 40; cyc++) begin
         if (valid0 && ready0) begin
            exp_w = exp_q.pop_front();
            checks++;
            if ({ipc0, out0} !== exp_w || addr0 !== 16'(ipc0 + 16'd1)) begin
               errors++;
               $display("FAIL start_seq: pc=%h out=%h addr=%h, want pc/out %h addr pc+1", ipc0, out0, addr0, exp_w);
            end
            if (exp_q.size() == 0) break;
         end
         @(negedge clk);
      end
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL start_timeout: %0d words left, want 0", exp_q.size());
         exp_q.delete();
      end
   endtask

   task automatic test_stall();
      @(negedge clk);
      ready0 = 0;
      checks++;
      if ({valid0, out0, ipc0, addr0} !== {1'b1, 16'd5, 16'd5, 16'd6}) begin
         errors++;
         $display("FAIL stall_entry: v=%0b out=%h pc=%h addr=%h, want 1 0005 0005 0006", valid0, out0, ipc0, addr0);
      end
      repeat (3) begin
         @(negedge clk);
         checks++;
         if ({valid0, out0, ipc0, addr0} !== {1'b1, 16'd5, 16'd5, 16'd6}) begin
            errors++;
            $display("FAIL stall_hold: v=%0b out=%h pc=%h addr=%h, want 1 0005 0005 0006", valid0, out0, ipc0, addr0);
         end
      end
      ready0 = 1;
      exp_q.push_back({16'd5, 16'd5});
      exp_q.push_back({16'd6, 16'd6});
      for (int cyc = 0; cyc < 40; cyc++) begin
         if (valid0 && ready0) begin
            exp_w = exp_q.pop_front();
            checks++;
            if ({ipc0, out0} !== exp_w || addr0 !== 16'(ipc0 + 16'd1)) begin
               errors++;
               $display("FAIL stall_seq: pc=%h out=%h addr=%h, want pc/out %h addr pc+1", ipc0, out0, addr0, exp_w);
            end
            if (exp_q.size() == 0) break;
         end
         @(negedge clk);
      end
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL stall_timeout: %0d words left, want 0", exp_q.size());
         exp_q.delete();
      end
   endtask

   task automatic test_redirect();
      @(negedge clk);
      checks++;
      if ({valid0, out0} !== {1'b1, 16'd7}) begin
         errors++;
         $display("FAIL redir_pre: v=%0b out=%h, want 1 0007", valid0, out0);
      end
      ready0 = 0; redirect0 = 1; rpc0 = 16'd20;
      @(negedge clk);
      redirect0 = 0;
      checks++;
      if ({valid0, addr0} !== {1'b0, 16'd20}) begin
         errors++;
         $display("FAIL redir_flush: v=%0b addr=%h, want 0 0014", valid0, addr0);
      end
      ready0 = 1;
      exp_q.push_back({16'd20, 16'd20});
      exp_q.push_back({16'd21, 16'd21});
      @(negedge clk);
      for (int cyc = 0; cyc < 40; cyc++) begin
         if (valid0 && ready0) begin
            exp_w = exp_q.pop_front();
            checks++;
            if ({ipc0, out0} !== exp_w || addr0 !== 16'(ipc0 + 16'd1)) begin
               errors++;
               $display("FAIL redir_seq: pc=%h out=%h addr=%h, want pc/out %h addr pc+1", ipc0, out0, addr0, exp_w);
            end
            if (exp_q.size() == 0) break;
         end
         @(negedge clk);
      end
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL redir_timeout: %0d words left, want 0", exp_q.size());
         exp_q.delete();
      end
   endtask

   task automatic test_halt();
      @(negedge clk);
      start1 = 1; ready1 = 1;
      @(negedge clk);
      start1 = 0;
      for (int i = 25; i <= 30; i++) exp_q.push_back({16'(i), 16'(i)});
      @(negedge clk);
      for (int cyc = 0; cyc < 40; cyc++) begin
         if (valid1 && ready1) begin
            exp_w = exp_q.pop_front();
            checks++;
            if ({ipc1, out1} !== exp_w || addr1 !== 16'(ipc1 + 16'd1)) begin
               errors++;
               $display("FAIL halt_seq: pc=%h out=%h addr=%h, want pc/out %h addr pc+1", ipc1, out1, addr1, exp_w);
            end
            if (exp_q.size() == 0) break;
         end
         @(negedge clk);
      end
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL halt_timeout: %0d words left, want 0", exp_q.size());
         exp_q.delete();
      end
      @(negedge clk);
      checks++;
      if ({halted1, valid1, addr1} !== {1'b1, 1'b0, 16'd31} || st1 !== ST_HALT) begin
         errors++;
         $display("FAIL halt_enter: h=%0b v=%0b addr=%h, want 1 0 001f", halted1, valid1, addr1);
      end
      start1 = 1;
      @(negedge clk);
      start1 = 0;
      checks++;
      if ({halted1, valid1, addr1} !== {1'b1, 1'b0, 16'd31}) begin
         errors++;
         $display("FAIL halt_hold: h=%0b v=%0b addr=%h, want 1 0 001f", halted1, valid1, addr1);
      end
      redirect1 = 1; rpc1 = 16'd3;
      @(negedge clk);
      redirect1 = 0;
      checks++;
      if ({halted1, valid1, addr1} !== {1'b0, 1'b0, 16'd3}) begin
         errors++;
         $display("FAIL halt_exit: h=%0b v=%0b addr=%h, want 0 0 0003", halted1, valid1, addr1);
      end
      for (int i = 3; i <= 5; i++) exp_q.push_back({16'(i), 16'(i)});
      @(negedge clk);
      for (int cyc = 0; cyc < 40; cyc++) begin
         if (valid1 && ready1) begin
            exp_w = exp_q.pop_front();
            checks++;
            if ({ipc1, out1} !== exp_w) begin
               errors++;
               $display("FAIL halt_resume: pc=%h out=%h, want pc/out %h", ipc1, out1, exp_w);
            end
            if (exp_q.size() == 0) break;
         end
         @(negedge clk);
      end
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL resume_timeout: %0d words left, want 0", exp_q.size());
         exp_q.delete();
      end
   endtask

   task automatic test_reset_mid();
      @(negedge clk);
      redirect0 = 1; rpc0 = 16'd12; ready0 = 0;
      @(negedge clk);
      redirect0 = 0;
      @(negedge clk);
      checks++;
      if ({valid0, out0, ipc0} !== {1'b1, 16'd12, 16'd12}) begin
         errors++;
         $display("FAIL rstmid_pre: v=%0b out=%h pc=%h, want 1 000c 000c", valid0, out0, ipc0);
      end
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if ({valid0, halted0, addr0} !== {1'b0, 1'b0, 16'd1} || st0 !== ST_IDLE) begin
         errors++;
         $display("FAIL rstmid_async: v=%0b h=%0b addr=%h st=%0d, want 0 0 0001 IDLE", valid0, halted0, addr0, st0);
      end
      @(negedge clk);
      rst_n = 1'b1;
      ready0 = 1;
      repeat (3) begin
         @(negedge clk);
         checks++;
         if ({valid0, addr0} !== {1'b0, 16'd1} || st0 !== ST_IDLE) begin
            errors++;
            $display("FAIL rstmid_idle: v=%0b addr=%h st=%0d, want 0 0001 IDLE", valid0, addr0, st0);
         end
      end
   endtask

   task automatic test_wrap();
      @(negedge clk);
      redirect0 = 1; start0 = 1; rpc0 = 16'hFFFF; ready0 = 1;
      @(negedge clk);
      redirect0 = 0; start0 = 0;
      checks++;
      if ({valid0, addr0} !== {1'b0, 16'hFFFF} || st0 !== ST_RUN) begin
         errors++;
         $display("FAIL wrap_redir: v=%0b addr=%h st=%0d, want 0 ffff RUN", valid0, addr0, st0);
      end
      exp_q.push_back({16'hFFFF, 16'h0000});
      exp_q.push_back({16'h0000, 16'h0000});
      exp_q.push_back({16'h0001, 16'h0001});
      exp_q.push_back({16'h0002, 16'h0002});
      @(negedge clk);
      for (int cyc = 0; cyc < 40; cyc++) begin
         if (valid0 && ready0) begin
            exp_w = exp_q.pop_front();
            checks++;
            if ({ipc0, out0} !== exp_w || addr0 !== 16'(ipc0 + 16'd1)) begin
               errors++;
               $display("FAIL wrap_seq: pc=%h out=%h addr=%h, want pc/out %h addr pc+1", ipc0, out0, addr0, exp_w);
            end
            if (exp_q.size() == 0) break;
         end
         @(negedge clk);
      end
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL wrap_timeout: %0d words left, want 0", exp_q.size());
         exp_q.delete();
      end
   endtask

   initial begin
      errors = 0;
      checks = 0;
      test_reset();
      test_start();
      test_stall();
      test_redirect();
      test_halt();
      test_reset_mid();
      test_wrap();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule : tb_fetch_controller
